// File: rtl/axis_frame_len_guard.sv
// rtl/axis_frame_len_guard.sv - AXI4-Stream frame length guard: truncates oversize frames, one status pulse per frame.
// Optional minimum-length (runt) check is compiled in with AXIS_FRAME_LEN_GUARD_RUNT_EN.
module axis_frame_len_guard #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1,
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
   parameter int MAX_LEN   = 1518,
   parameter int MIN_LEN   = 60,
   parameter int LEN_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  status_valid,
   output logic [LEN_WIDTH-1:0]  status_len,
   output logic                  status_oversize,
   output logic                  status_bad,
   output logic                  status_runt
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

   typedef enum logic {
      ST_PASS = 1'b0,
      ST_DROP = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
   logic                  m_tvalid_q, m_tvalid_d;
   logic                  m_tlast_q, m_tlast_d;
   logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;
   logic                  st_valid_q, st_valid_d;
   logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;
   logic                  st_over_q, st_over_d;
   logic                  st_bad_q, st_bad_d;
   logic                  st_runt_q, st_runt_d;

   logic                  s_ready;
   logic                  accept;
   logic [LEN_WIDTH-1:0]  beat_bytes;
   logic [LEN_WIDTH-1:0]  sum;
   logic [LEN_WIDTH-1:0]  rem;
   logic                  over;
   logic [KEEP_WIDTH-1:0] trunc_keep;
   logic                  user_bad;
   logic                  runt_hit;

   // DROP sinks beats unconditionally; PASS only takes a beat when the output slot frees up.
   assign s_ready       = (state_q == ST_DROP) || m_axis_tready || !m_tvalid_q;
   assign s_axis_tready = rst_n && s_ready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign user_bad      = ((s_axis_tuser & USER_BAD_FRAME_MASK) ==
                           (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         beat_bytes = beat_bytes + LEN_WIDTH'(s_axis_tkeep[i]);
      end
      sum  = cnt_q + beat_bytes;
      over = (sum > MAX_LEN_L);
      rem  = MAX_LEN_L - cnt_q;
      trunc_keep = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         trunc_keep[i] = s_axis_tkeep[i] && (LEN_WIDTH'(i) < rem);
      end
   end

`ifdef AXIS_FRAME_LEN_GUARD_RUNT_EN
   assign runt_hit = s_axis_tlast && !over && (sum < LEN_WIDTH'(MIN_LEN));
`else
   logic [LEN_WIDTH-1:0] unused_min_len;
   assign unused_min_len = LEN_WIDTH'(MIN_LEN);
   assign runt_hit       = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      m_tdata_d  = m_tdata_q;
      m_tkeep_d  = m_tkeep_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tuser_d  = m_tuser_q;
      st_valid_d = 1'b0;
      st_len_d   = st_len_q;
      st_over_d  = st_over_q;
      st_bad_d   = st_bad_q;
      st_runt_d  = st_runt_q;

      if (m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end

      if (accept) begin
         if (state_q == ST_DROP) begin
            if (s_axis_tlast) begin
               state_d = ST_PASS;
            end
         end else begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata;
            if (over) begin
               // Cut the frame here; the count can already sit at MAX_LEN, giving an empty tkeep.
               m_tkeep_d = trunc_keep;
               m_tlast_d = 1'b1;
               m_tuser_d = USER_BAD_FRAME_VALUE;
               cnt_d     = '0;
               if (!s_axis_tlast) begin
                  state_d = ST_DROP;
               end
            end else begin
               m_tkeep_d = s_axis_tkeep;
               m_tlast_d = s_axis_tlast;
               m_tuser_d = runt_hit ? USER_BAD_FRAME_VALUE : s_axis_tuser;
               cnt_d     = s_axis_tlast ? '0 : sum;
            end
            if (over || s_axis_tlast) begin
               st_valid_d = 1'b1;
               st_len_d   = over ? MAX_LEN_L : sum;
               st_over_d  = over;
               st_bad_d   = over || runt_hit || user_bad;
               st_runt_d  = runt_hit;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_PASS;
         cnt_q      <= '0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tuser_q  <= '0;
         st_valid_q <= 1'b0;
         st_len_q   <= '0;
         st_over_q  <= 1'b0;
         st_bad_q   <= 1'b0;
         st_runt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tuser_q  <= m_tuser_d;
         st_valid_q <= st_valid_d;
         st_len_q   <= st_len_d;
         st_over_q  <= st_over_d;
         st_bad_q   <= st_bad_d;
         st_runt_q  <= st_runt_d;
      end
   end

   assign m_axis_tdata    = m_tdata_q;
   assign m_axis_tkeep    = m_tkeep_q;
   assign m_axis_tvalid   = m_tvalid_q;
   assign m_axis_tlast    = m_tlast_q;
   assign m_axis_tuser    = m_tuser_q;
   assign status_valid    = st_valid_q;
   assign status_len      = st_len_q;
   assign status_oversize = st_over_q;
   assign status_bad      = st_bad_q;
   assign status_runt     = st_runt_q;

endmodule

// File: tb/tb_axis_frame_len_guard.sv
// tb/tb_axis_frame_len_guard.sv - self-checking bench for axis_frame_len_guard with a frame-level model.
module tb_axis_frame_len_guard;

   localparam int MAX_LEN = 1518;
   localparam int MIN_LEN = 60;
`ifdef AXIS_FRAME_LEN_GUARD_RUNT_EN
   localparam bit RUNT = 1'b1;
`else
   localparam bit RUNT = 1'b0;
`endif

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct {
      int len;
      bit ov;
      bit bad;
      bit runt;
   } st_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [0:0]  s_axis_tuser = '0;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [0:0]  m_axis_tuser;
   logic        status_valid;
   logic [15:0] status_len;
   logic        status_oversize;
   logic        status_bad;
   logic        status_runt;

   int    n_total = 0;
   int    n_bad = 0;
   int    n_out = 0;
   int    rdy_mode = 0;
   bit    chk_en = 1'b0;
   int    last_status_len = -1;
   beat_t frame_q[$];
   beat_t exp_q[$];
   st_t   st_q[$];

   axis_frame_len_guard #(
      .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1),
      .USER_BAD_FRAME_VALUE(1'b1), .USER_BAD_FRAME_MASK(1'b1),
      .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .LEN_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .status_valid(status_valid), .status_len(status_len), .status_oversize(status_oversize),
      .status_bad(status_bad), .status_runt(status_runt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] keep_lo(input int k);
      logic [8:0] t;
      t = (9'd1 << k) - 9'd1;
      return t[7:0];
   endfunction

   // Frame of len bytes: full beats, last beat partially kept; user only on the last beat.
   task automatic build(input int len, input bit user, input int tag);
      int    nb;
      beat_t b;
      frame_q.delete();
      nb = (len + 7) / 8;
      for (int i = 0; i < nb; i++) begin
         b.data = {8'(tag), 24'(i), 32'($urandom)};
         b.keep = (len - 8 * i >= 8) ? 8'hFF : keep_lo(len - 8 * i);
         b.last = (i == nb - 1);
         b.user = b.last ? user : 1'b0;
         frame_q.push_back(b);
      end
   endtask

   // Frame-level expectation: bytes pass until MAX_LEN would be exceeded, then one cut beat and stop.
   task automatic model_frame();
      int    total;
      int    n;
      beat_t o;
      st_t   s;
      total = 0;
      foreach (frame_q[i]) begin
         o = frame_q[i];
         n = $countones(o.keep);
         if (total + n > MAX_LEN) begin
            o.keep = keep_lo(MAX_LEN - total);
            o.last = 1'b1;
            o.user = 1'b1;
            exp_q.push_back(o);
            s.len = MAX_LEN; s.ov = 1'b1; s.bad = 1'b1; s.runt = 1'b0;
            st_q.push_back(s);
            return;
         end
         total += n;
         if (o.last) begin
            s.runt = RUNT && (total < MIN_LEN);
            if (s.runt) o.user = 1'b1;
            s.len = total; s.ov = 1'b0; s.bad = o.user;
            exp_q.push_back(o);
            st_q.push_back(s);
            return;
         end
         exp_q.push_back(o);
      end
   endtask

   // Entered at a negedge; returns at the negedge after the handshake edge.
   task automatic send_beat(input beat_t b);
      int g;
      g = 0;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tuser  = b.user;
      s_axis_tvalid = 1'b1;
      forever begin
         #4;
         if (s_axis_tready) begin
            @(negedge clk);
            break;
         end
         @(negedge clk);
         g++;
         if (g > 4000) begin
            chk("send_timeout", 64'(g), 64'(0));
            break;
         end
      end
   endtask

   task automatic send_frame();
      foreach (frame_q[i]) send_beat(frame_q[i]);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic run_frame(input int len, input bit user, input int tag);
      build(len, user, tag);
      model_frame();
      send_frame();
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || st_q.size() != 0) && g < 3000) begin
         @(negedge clk);
         g++;
      end
      repeat (2) @(negedge clk);
      chk("drain", 64'(exp_q.size() + st_q.size()), 64'(0));
   endtask

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // Compare process: samples just before each rising edge.
   initial begin
      bit          prev_stall;
      bit          first_last;
      logic [63:0] held_data;
      logic [9:0]  held_ctl;
      beat_t       e;
      st_t         s;
      prev_stall = 1'b0;
      held_data  = '0;
      held_ctl   = '0;
      forever begin
         @(negedge clk);
         #4;
         if (!chk_en || !rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            chk("hold_data", m_axis_tdata, held_data);
            chk("hold_ctl", 64'({m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                64'({1'b1, held_ctl}));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_axis_tdata, e.data);
               chk("beat_ctl", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                   64'({e.keep, e.last, e.user}));
            end
         end
         first_last = m_axis_tvalid && m_axis_tlast && !prev_stall;
         if (status_valid || first_last) begin
            chk("st_align", 64'(status_valid), 64'(first_last));
         end
         if (status_valid) begin
            last_status_len = int'(status_len);
            if (st_q.size() == 0) begin
               chk("st_unexpected", 64'(1), 64'(0));
            end else begin
               s = st_q.pop_front();
               chk("st_len", 64'(status_len), 64'(s.len));
               chk("st_flags", 64'({status_oversize, status_bad, status_runt}),
                   64'({s.ov, s.bad, s.runt}));
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         held_data  = m_axis_tdata;
         held_ctl   = {m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      end
   end

   initial begin
      int    n0;
      int    base;
      beat_t b;

      repeat (3) @(negedge clk);
      chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("rst_m_bus", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'(0));
      chk("rst_m_tdata", m_axis_tdata, 64'(0));
      chk("rst_status", 64'({status_valid, status_len, status_oversize, status_bad, status_runt}),
          64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // 64-byte frame, one-cycle latency
      rdy_mode = 0;
      build(64, 1'b0, 1);
      model_frame();
      chk("pin_beats64", 64'(exp_q.size()), 64'(8));
      chk("pin_len64", 64'(st_q[$].len), 64'(64));
      chk("lat_idle", 64'(m_axis_tvalid), 64'(0));
      send_beat(frame_q[0]);
      chk("lat_valid", 64'(m_axis_tvalid), 64'(1));
      chk("lat_data", m_axis_tdata, frame_q[0].data);
      for (int i = 1; i < frame_q.size(); i++) send_beat(frame_q[i]);
      s_axis_tvalid = 1'b0;
      drain();

      // 1600-byte frame truncated, then a normal frame
      rdy_mode = 1;
      n0 = n_out;
      build(1600, 1'b0, 2);
      base = exp_q.size();
      model_frame();
      chk("pin_beats1600", 64'(exp_q.size() - base), 64'(190));
      chk("pin_keep1600", 64'({exp_q[$].keep, exp_q[$].last, exp_q[$].user}), 64'({8'h3F, 2'b11}));
      chk("pin_len1600", 64'({st_q[$].len, st_q[$].ov, st_q[$].bad}), 64'({32'd1518, 2'b11}));
      send_frame();
      run_frame(64, 1'b0, 3);
      drain();
      chk("out_cnt_1600", 64'(n_out - n0), 64'(198));

      // exactly MAX_LEN
      build(1518, 1'b0, 4);
      model_frame();
      chk("pin_exact", 64'({st_q[$].len, st_q[$].ov}), 64'({32'd1518, 1'b0}));
      send_frame();

      // count reaches MAX_LEN exactly, then one more beat: empty cut beat
      build(1518, 1'b0, 5);
      frame_q[frame_q.size() - 1].last = 1'b0;
      b.data = 64'hDEAD_BEEF_0000_0005; b.keep = 8'hFF; b.last = 1'b1; b.user = 1'b0;
      frame_q.push_back(b);
      model_frame();
      chk("pin_zero_cut", 64'({exp_q[$].keep, exp_q[$].last, exp_q[$].user}), 64'({8'h00, 2'b11}));
      send_frame();

      // truncating beat carries tlast itself; next frame has bad tuser
      build(1520, 1'b0, 6);
      model_frame();
      chk("pin_cut_last", 64'(exp_q[$].keep), 64'(8'h3F));
      send_frame();
      run_frame(64, 1'b1, 7);

      // zero-tkeep final beat counts as 0 bytes
      build(16, 1'b0, 8);
      frame_q[1].last = 1'b0;
      b.data = 64'h0123_4567_89AB_CDEF; b.keep = 8'h00; b.last = 1'b1; b.user = 1'b0;
      frame_q.push_back(b);
      model_frame();
      chk("pin_zero_keep", 64'(st_q[$].len), 64'(16));
      send_frame();

      // short frame
      build(40, 1'b0, 9);
      model_frame();
      chk("pin_short", 64'({st_q[$].len, st_q[$].runt, exp_q[$].user}), 64'({32'd40, RUNT, RUNT}));
      send_frame();
      drain();

      // back-to-back 100-byte frames under random backpressure
      rdy_mode = 1;
      n0 = n_out;
      for (int f = 0; f < 6; f++) run_frame(100, 1'(f % 2), 10 + f);
      rdy_mode = 0;
      drain();
      chk("out_cnt_100", 64'(n_out - n0), 64'(78));

      // reset in the middle of an oversize frame
      chk_en = 1'b0;
      build(1600, 1'b0, 20);
      for (int i = 0; i < 5; i++) send_beat(frame_q[i]);
      s_axis_tvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 64'({m_axis_tvalid, m_axis_tlast}), 64'(0));
      chk("mid_rst_bus", 64'({m_axis_tkeep, m_axis_tuser}), 64'(0));
      chk("mid_rst_tdata", m_axis_tdata, 64'(0));
      chk("mid_rst_tready", 64'(s_axis_tready), 64'(0));
      chk("mid_rst_status", 64'({status_valid, status_len, status_oversize, status_bad}), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      run_frame(64, 1'b0, 21);
      drain();
      chk("post_rst_len", 64'(last_status_len), 64'(64));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_frame_len_guard.md
# axis_frame_len_guard

Single-clock AXI4-Stream frame length guard on the output side of the asynchronous FIFO/width-adapter stage. It counts bytes per frame from tkeep and forwards conforming frames unchanged. Frames longer than MAX_LEN are truncated at exactly MAX_LEN bytes, marked bad in tuser, and the remainder is discarded. One status pulse per frame reports the forwarded length and error flags.

## Interface
Parameters:
- DATA_WIDTH, 64: tdata width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width in bytes.
- USER_WIDTH, 1: tuser width.
- USER_BAD_FRAME_VALUE, 1'b1: tuser value that marks a bad frame.
- USER_BAD_FRAME_MASK, 1'b1: tuser bits compared against the bad-frame value.
- MAX_LEN, 1518: maximum frame length in bytes; must be ≥ KEEP_WIDTH.
- MIN_LEN, 60: minimum frame length in bytes; used only when the runt check is compiled in.
- LEN_WIDTH, 16: width of the length counter and status field; 2^LEN_WIDTH must exceed MAX_LEN+KEEP_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata / tkeep / tvalid / tready(out) / tlast / tuser  in  DATA_WIDTH / KEEP_WIDTH / 1 / 1 / 1 / USER_WIDTH  input stream.
- m_axis_tdata / tkeep / tvalid / tready(in) / tlast / tuser  out  same widths  output stream.
- status_valid  out  1  single-cycle pulse, one per forwarded frame.
- status_len  out  LEN_WIDTH  forwarded byte count of that frame.
- status_oversize  out  1  frame was truncated.
- status_bad  out  1  frame left with a bad tuser.
- status_runt  out  1  frame shorter than MIN_LEN; tied 0 when the runt check is compiled out.

## Operation
- tkeep is low-aligned and contiguous. Beat bytes are popcount(tkeep), and a zero-tkeep beat counts as 0 bytes.
- State machine with two states:
  - PASS (reset state): forwards accepted beats.
  - DROP: s_axis_tready=1, m_axis_tvalid unaffected; beats are consumed and discarded. On an accepted beat with tlast it returns to PASS.
- In PASS, the block computes sum = cnt + beat_bytes on each accepted beat:
  - If sum ≤ MAX_LEN, the beat is forwarded unchanged and cnt takes sum, or 0 when tlast.
  - If sum > MAX_LEN, the beat is forwarded with tkeep masked to its lowest (MAX_LEN−cnt) bytes, tlast=1 and tuser=USER_BAD_FRAME_VALUE, and cnt is cleared. The state moves to DROP if the input tlast=0 and stays in PASS if tlast=1.
  - The masked count MAX_LEN−cnt can be 0, because cnt can equal MAX_LEN exactly. In that case the emitted beat has tkeep=0, tlast=1 and tuser bad.
- Status fires when the output tlast beat is loaded into the output register:
  - status_len = forwarded bytes, saturating at MAX_LEN.
  - status_oversize = truncated.
  - status_bad = truncated, or the final tuser matches the bad value under the mask.
- Reset mid-frame clears cnt, returns to PASS and empties the output register. The next accepted beat starts a new frame.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, s_axis_tready=0 while rst_n=0, and all status outputs 0.

## Timing
- Latency is 1 cycle, with a single output register stage.
- s_axis_tready = 1 in DROP. Otherwise s_axis_tready = m_axis_tready || !m_axis_tvalid.
- Full throughput at one beat per cycle under continuous m_axis_tready.
- m_axis_* are held stable while tvalid=1 and tready=0.
- status_valid is registered and coincides with the cycle in which the tlast beat first appears on m_axis_tvalid. It is not delayed by backpressure.
- DROP discards at one beat per cycle regardless of m_axis_tready.
- A frame whose last beat is accepted in the same cycle as the next frame's first beat is impossible; beats are serial. Back-to-back frames need no idle cycle.

## Configuration
- Macro: AXIS_FRAME_LEN_GUARD_RUNT_EN.
- Defined: on the tlast beat, if the final length < MIN_LEN, the block forces tuser to USER_BAD_FRAME_VALUE and asserts status_runt and status_bad. The frame is still forwarded with no padding.
- Undefined: no minimum check, status_runt is tied 0, and MIN_LEN is ignored.

## Test plan
- DATA_WIDTH=64, MAX_LEN=1518; send a 64-byte frame of 8 full beats -> identical 8 beats out, status_len=64, oversize=0, bad=0, 1-cycle latency.
- 1600-byte frame of 200 beats -> 190 beats out, last beat tkeep=0x3F, tlast=1, tuser=1; status_len=1518, oversize=1, bad=1. The remaining 10 beats are consumed with no output, then the next frame passes normally.
- Frame of exactly 1518 bytes (last beat tkeep=0x3F) -> passed unchanged, oversize=0.
- Random m_axis_tready (50%) with back-to-back 100-byte frames -> no data loss or duplication, and output held stable under stall.
- rst_n asserted at beat 5 of a 1600-byte frame -> outputs go to reset values immediately; after release, a 64-byte frame passes with status_len=64.
- With AXIS_FRAME_LEN_GUARD_RUNT_EN: a 40-byte frame -> forwarded, tuser=1 on tlast, status_runt=1, status_len=40.
